// File: rtl/mlp_layer_sequencer.sv
// Multi-layer MLP sequencer: walks layer configs, streams MAC batches,
// triggers activation and writes neuron results into ping-pong banks.
module mlp_layer_sequencer #(
  parameter int LANES      = 8,
  parameter int ADDR_W     = 16,
  parameter int MAX_LAYERS = 4,
  parameter int MEM_LAT    = 1,
  localparam int LW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LW:0]       cfg_layer_count,
  output logic [LW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_num_in,
  input  logic [ADDR_W-1:0] cfg_num_out,
  input  logic [1:0]        cfg_act,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              act_rd_bank,
  output logic [ADDR_W-1:0] wt_rd_addr,
  output logic [ADDR_W-1:0] bias_rd_addr,
  output logic              mac_enable,
  output logic              mac_clear,
  output logic              mac_last,
  output logic [LANES-1:0]  lane_mask,
  input  logic              mac_valid,
  output logic              act_enable,
  output logic [1:0]        act_type,
  input  logic              result_valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic              out_wr_bank,
  output logic [LW-1:0]     layer_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int LG = $clog2(LANES);
  localparam int PW = LANES + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_INIT, S_ISSUE, S_DRAIN,
    S_ACT, S_WRES, S_STORE, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic start_q, start_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [ADDR_W-1:0] bias_q, bias_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] neuron_q, neuron_d;
  logic [ADDR_W-1:0] batch_q, batch_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [ADDR_W-1:0] num_in_q, num_in_d;
  logic [ADDR_W-1:0] num_out_q, num_out_d;
  logic [ADDR_W-1:0] nb_q, nb_d;
  logic [LG-1:0] rem_q, rem_d;
  logic [1:0] act_q, act_d;
  logic bank_q, bank_d;
  logic err_q, err_d;
  logic seen_q, seen_d;
  logic [PW-1:0] pipe_q [MEM_LAT];
  logic [PW-1:0] pipe_d [MEM_LAT];

  logic launch, cfg_bad, issue_last;
  logic more_n, more_l, kill;
  logic [LANES-1:0] mask;
  logic [PW-1:0] pipe_out;

  assign kill       = abort && (state_q != S_IDLE);
  assign launch     = start && !start_q;
  assign cfg_bad    = (cfg_num_in == '0) || (cfg_num_out == '0) ||
                      (cfg_layer_count == '0) ||
                      (cfg_layer_count > (LW+1)'(MAX_LAYERS));
  assign issue_last = batch_q == (nb_q - ADDR_W'(1));
  assign more_n     = (neuron_q + ADDR_W'(1)) < num_out_q;
  assign more_l     = ({1'b0, layer_q} + (LW+1)'(1)) < cfg_layer_count;
  assign pipe_out   = pipe_q[MEM_LAT-1];

  always_comb begin
    mask = '1;
    if (issue_last && rem_q != '0) mask = LANES'((1 << rem_q) - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      layer_q    <= '0;
      bias_q     <= '0;
      wptr_q     <= '0;
      neuron_q   <= '0;
      batch_q    <= '0;
      act_addr_q <= '0;
      wt_addr_q  <= '0;
      num_in_q   <= '0;
      num_out_q  <= '0;
      nb_q       <= '0;
      rem_q      <= '0;
      act_q      <= '0;
      bank_q     <= 1'b0;
      err_q      <= 1'b0;
      seen_q     <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      layer_q    <= layer_d;
      bias_q     <= bias_d;
      wptr_q     <= wptr_d;
      neuron_q   <= neuron_d;
      batch_q    <= batch_d;
      act_addr_q <= act_addr_d;
      wt_addr_q  <= wt_addr_d;
      num_in_q   <= num_in_d;
      num_out_q  <= num_out_d;
      nb_q       <= nb_d;
      rem_q      <= rem_d;
      act_q      <= act_d;
      bank_q     <= bank_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (launch) state_d = S_CFG;
      S_CFG:   state_d = cfg_bad ? S_DONE : S_INIT;
      S_INIT:  state_d = S_ISSUE;
      S_ISSUE: if (issue_last) state_d = S_DRAIN;
      S_DRAIN: if (seen_q && mac_valid) state_d = S_ACT;
      S_ACT:   state_d = S_WRES;
      S_WRES:  if (result_valid) state_d = S_STORE;
      S_STORE: begin
        if (more_n)      state_d = S_INIT;
        else if (more_l) state_d = S_CFG;
        else             state_d = S_DONE;
      end
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb begin
    start_d    = start;
    layer_d    = layer_q;
    bias_d     = bias_q;
    wptr_d     = wptr_q;
    neuron_d   = neuron_q;
    batch_d    = batch_q;
    act_addr_d = act_addr_q;
    wt_addr_d  = wt_addr_q;
    num_in_d   = num_in_q;
    num_out_d  = num_out_q;
    nb_d       = nb_q;
    rem_d      = rem_q;
    act_d      = act_q;
    bank_d     = bank_q;
    err_d      = err_q;
    seen_d     = seen_q;
    // Issue strobes enter the delay line so they meet the BRAM data.
    pipe_d[0] = (state_q == S_ISSUE) ? {1'b1, issue_last, mask} : '0;
    for (int i = 1; i < MEM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    if (pipe_out[PW-2]) seen_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          layer_d = '0;
          bias_d  = '0;
          wptr_d  = '0;
          bank_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_CFG: begin
        num_in_d  = cfg_num_in;
        num_out_d = cfg_num_out;
        act_d     = cfg_act;
        nb_d      = (cfg_num_in >> LG) +
                    ADDR_W'(|cfg_num_in[LG-1:0]);
        rem_d     = cfg_num_in[LG-1:0];
        err_d     = cfg_bad;
        neuron_d  = '0;
      end
      S_INIT: begin
        batch_d    = '0;
        act_addr_d = '0;
        wt_addr_d  = wptr_q;
        seen_d     = 1'b0;
      end
      S_ISSUE: begin
        batch_d    = batch_q + ADDR_W'(1);
        act_addr_d = act_addr_q + ADDR_W'(LANES);
        wt_addr_d  = wt_addr_q + ADDR_W'(LANES);
      end
      S_STORE: begin
        neuron_d = neuron_q + ADDR_W'(1);
        bias_d   = bias_q + ADDR_W'(1);
        wptr_d   = wptr_q + num_in_q;
        if (!more_n && more_l) begin
          layer_d = layer_q + LW'(1);
          bank_d  = ~bank_q;
        end
      end
      default: ;
    endcase
    if (kill) begin
      err_d  = 1'b0;
      seen_d = 1'b0;
      for (int i = 0; i < MEM_LAT; i++) pipe_d[i] = '0;
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mac_clear  = 1'b0;
    act_enable = 1'b0;
    out_wr_en  = 1'b0;
    unique case (state_q)
      S_CFG, S_ISSUE, S_DRAIN, S_WRES: busy = 1'b1;
      S_INIT: begin
        busy      = 1'b1;
        mac_clear = !abort;
      end
      S_ACT: begin
        busy       = 1'b1;
        act_enable = !abort;
      end
      S_STORE: begin
        busy      = 1'b1;
        out_wr_en = !abort;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    error      = done && err_q;
    mac_enable = pipe_out[PW-1] && !abort;
    mac_last   = pipe_out[PW-2] && !abort;
    lane_mask  = abort ? '0 : pipe_out[LANES-1:0];
  end

  assign cfg_idx      = layer_q;
  assign layer_idx    = layer_q;
  assign act_rd_addr  = act_addr_q;
  assign act_rd_bank  = bank_q;
  assign wt_rd_addr   = wt_addr_q;
  assign bias_rd_addr = bias_q;
  assign act_type     = act_q;
  assign out_wr_addr  = neuron_q;
  assign out_wr_bank  = busy & ~bank_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Randomized bench for mlp_layer_sequencer: datapath/regfile models
// plus a layer-level reference of beats, activations and writes.
module tb_mlp_layer_sequencer;
  localparam int LANES = 8;
  localparam int AW    = 16;
  localparam int MAXL  = 4;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [2:0] cfg_layer_count = '0;
  logic [1:0] cfg_idx;
  logic [AW-1:0] cfg_num_in, cfg_num_out;
  logic [1:0] cfg_act;
  logic [AW-1:0] act_rd_addr, wt_rd_addr, bias_rd_addr, out_wr_addr;
  logic act_rd_bank, mac_enable, mac_clear, mac_last;
  logic [LANES-1:0] lane_mask;
  logic mac_valid = 1'b0;
  logic result_valid = 1'b0;
  logic act_enable, out_wr_en, out_wr_bank;
  logic [1:0] act_type, layer_idx;
  logic busy, done, error;

  logic [AW-1:0] l_in [MAXL];
  logic [AW-1:0] l_out [MAXL];
  logic [1:0] l_act [MAXL];

  assign cfg_num_in  = l_in[cfg_idx];
  assign cfg_num_out = l_out[cfg_idx];
  assign cfg_act     = l_act[cfg_idx];

  mlp_layer_sequencer #(
    .LANES(LANES), .ADDR_W(AW), .MAX_LAYERS(MAXL), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_layer_count(cfg_layer_count), .cfg_idx(cfg_idx),
    .cfg_num_in(cfg_num_in), .cfg_num_out(cfg_num_out),
    .cfg_act(cfg_act), .act_rd_addr(act_rd_addr),
    .act_rd_bank(act_rd_bank), .wt_rd_addr(wt_rd_addr),
    .bias_rd_addr(bias_rd_addr), .mac_enable(mac_enable),
    .mac_clear(mac_clear), .mac_last(mac_last),
    .lane_mask(lane_mask), .mac_valid(mac_valid),
    .act_enable(act_enable), .act_type(act_type),
    .result_valid(result_valid), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .out_wr_bank(out_wr_bank),
    .layer_idx(layer_idx), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] w;
    logic [7:0]  m;
    logic        l;
  } beat_t;
  typedef struct packed {
    logic [15:0] bias;
    logic [1:0]  t;
    logic [15:0] n;
  } act_t;
  typedef struct packed {
    logic [15:0] a;
    logic        b;
    logic        rb;
    logic [1:0]  li;
  } wr_t;

  beat_t obs_b[$], exp_b[$];
  act_t  obs_a[$], exp_a[$];
  wr_t   obs_w[$], exp_w[$];
  int n_clr, exp_clr, beat_cnt;
  logic [15:0] ha [LAT];
  logic [15:0] hw [LAT];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe what the datapath sees; addresses are matched LAT cycles back.
  always @(negedge clk) begin
    if (mac_clear) begin
      n_clr++;
      beat_cnt = 0;
    end
    if (mac_enable) begin
      beat_t bt;
      bt.a = ha[LAT-1];
      bt.w = hw[LAT-1];
      bt.m = lane_mask;
      bt.l = mac_last;
      obs_b.push_back(bt);
      beat_cnt++;
    end
    if (act_enable) begin
      act_t at;
      at.bias = bias_rd_addr;
      at.t = act_type;
      at.n = 16'(beat_cnt);
      obs_a.push_back(at);
    end
    if (out_wr_en) begin
      wr_t wt;
      wt.a = out_wr_addr;
      wt.b = out_wr_bank;
      wt.rb = act_rd_bank;
      wt.li = layer_idx;
      obs_w.push_back(wt);
    end
    for (int i = LAT - 1; i > 0; i--) begin
      ha[i] = ha[i-1];
      hw[i] = hw[i-1];
    end
    ha[0] = act_rd_addr;
    hw[0] = wt_rd_addr;
  end

  // Datapath model: spurious early mac_valid, real one after mac_last.
  int mdly, rdly;
  bit mwait, rwait;
  always @(negedge clk) begin
    if (!rst_n || abort) begin
      mac_valid = 1'b0;
      result_valid = 1'b0;
      mwait = 1'b0;
      rwait = 1'b0;
    end else begin
      if (act_enable) begin
        mac_valid = 1'b0;
        mwait = 1'b0;
        rwait = 1'b1;
        rdly = $urandom_range(0, 3);
      end else if (mwait) begin
        if (mdly > 0) mdly--;
        else mac_valid = 1'b1;
      end else if (mac_last) begin
        mwait = 1'b1;
        mdly = $urandom_range(0, 2);
        mac_valid = 1'b0;
      end else begin
        mac_valid = ($urandom_range(0, 2) == 0);
      end
      if (out_wr_en) begin
        result_valid = 1'b0;
        rwait = 1'b0;
      end else if (rwait) begin
        if (rdly > 0) rdly--;
        else result_valid = 1'b1;
      end
    end
  end

  task automatic clear_obs();
    obs_b.delete();
    obs_a.delete();
    obs_w.delete();
    n_clr = 0;
  endtask

  task automatic build_model(input int cnt, output bit err);
    int bias, wptr, nb, rem;
    beat_t bt;
    act_t at;
    wr_t wt;
    exp_b.delete();
    exp_a.delete();
    exp_w.delete();
    exp_clr = 0;
    bias = 0;
    wptr = 0;
    err = (cnt == 0) || (cnt > MAXL);
    for (int l = 0; l < cnt && !err; l++) begin
      if (l_in[l] == 0 || l_out[l] == 0) begin
        err = 1'b1;
        break;
      end
      nb = (int'(l_in[l]) + LANES - 1) / LANES;
      rem = int'(l_in[l]) % LANES;
      for (int n = 0; n < int'(l_out[l]); n++) begin
        exp_clr++;
        for (int b = 0; b < nb; b++) begin
          bt.a = 16'(b * LANES);
          bt.w = 16'(wptr + b * LANES);
          bt.l = (b == nb - 1);
          bt.m = (bt.l && rem != 0) ? 8'((1 << rem) - 1) : 8'hff;
          exp_b.push_back(bt);
        end
        at.bias = 16'(bias);
        at.t = l_act[l];
        at.n = 16'(nb);
        exp_a.push_back(at);
        wt.a = 16'(n);
        wt.b = (l % 2 == 0);
        wt.rb = (l % 2 == 1);
        wt.li = 2'(l);
        exp_w.push_back(wt);
        bias++;
        wptr += int'(l_in[l]);
      end
    end
  endtask

  task automatic compare();
    chk("beat_count", 64'(obs_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++)
      chk($sformatf("beat%0d", i), 64'(obs_b[i]), 64'(exp_b[i]));
    chk("act_count", 64'(obs_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
      chk($sformatf("act%0d", i), 64'(obs_a[i]), 64'(exp_a[i]));
    chk("wr_count", 64'(obs_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      chk($sformatf("wr%0d", i), 64'(obs_w[i]), 64'(exp_w[i]));
    chk("clears", 64'(n_clr), 64'(exp_clr));
  endtask

  task automatic run(input int cnt);
    bit err;
    int cyc;
    cfg_layer_count = 3'(cnt);
    build_model(cnt, err);
    clear_obs();
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 4000);
    chk("done", 64'(done), 64'(1));
    chk("error", 64'(error), 64'(err));
    if (err) chk("err_latency", 64'(cyc <= 3), 64'(1));
    repeat (3) @(negedge clk);
    chk("done_held", 64'(done), 64'(1));
    chk("no_relaunch", 64'(busy), 64'(0));
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_clr", 64'({done, error, busy}), 64'(0));
    compare();
  endtask

  task automatic set_layer(input int l, input int ni, input int no,
                           input int a);
    l_in[l] = 16'(ni);
    l_out[l] = 16'(no);
    l_act[l] = 2'(a);
  endtask

  task automatic set_three();
    set_layer(0, 4, 3, 0);
    set_layer(1, 3, 2, 1);
    set_layer(2, 2, 1, 2);
    set_layer(3, 1, 1, 3);
  endtask

  initial begin
    int cyc, nwr;
    for (int l = 0; l < MAXL; l++) set_layer(l, 1, 1, 0);
    for (int i = 0; i < LAT; i++) begin
      ha[i] = '0;
      hw[i] = '0;
    end
    n_clr = 0;
    beat_cnt = 0;
    @(negedge clk);
    chk("rst_flags", 64'({busy, done, error, mac_enable, mac_clear,
        mac_last, act_enable, out_wr_en, out_wr_bank, act_rd_bank}), 64'(0));
    chk("rst_addrs", {act_rd_addr, wt_rd_addr, bias_rd_addr, out_wr_addr},
        64'(0));
    chk("rst_misc", 64'({lane_mask, act_type, layer_idx, cfg_idx}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_layer(0, 16, 2, 0);
    run(1);
    set_layer(0, 13, 3, 1);
    run(1);
    set_three();
    run(3);

    set_layer(0, 9, 0, 1);
    run(1);
    set_three();
    run(5);
    run(0);
    set_layer(0, 0, 2, 0);
    run(2);

    set_layer(0, 16, 1, 1);
    set_layer(1, 40, 2, 2);
    cfg_layer_count = 3'd2;
    clear_obs();
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mac_clear && layer_idx == 2'd1) && cyc < 2000);
    chk("abort_reach", 64'(layer_idx), 64'(1));
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    start = 1'b0;
    nwr = obs_w.size();
    @(negedge clk);
    chk("abort_strobes", 64'({mac_enable, mac_last, mac_clear, act_enable,
        out_wr_en, lane_mask}), 64'(0));
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'({busy, done, error, mac_enable, mac_last,
        mac_clear, act_enable, out_wr_en, lane_mask}), 64'(0));
    repeat (10) @(negedge clk);
    chk("abort_nowr", 64'(obs_w.size()), 64'(nwr));
    chk("abort_busy", 64'(busy), 64'(0));
    set_three();
    run(3);

    for (int r = 0; r < 6; r++) begin
      for (int l = 0; l < MAXL; l++)
        set_layer(l, $urandom_range(1, 40), $urandom_range(1, 4),
                  $urandom_range(0, 3));
      run($urandom_range(1, MAXL));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
Parametrised multi-layer sequencer for the MLP accelerator. It steps through up to MAX_LAYERS fully-connected layers. For each layer it reads the layer's configuration, streams LANES-wide input/weight batches to the MAC datapath at one batch per cycle, masks the partial final batch, then triggers bias add and activation and writes each neuron result. Activation buffers ping-pong between two banks from layer to layer. It sits between the host register file and the MAC/activation datapath and the activation/weight/bias BRAMs.

Parameters:
LANES, 8, inputs/weights consumed per MAC batch; power of two, 2..32
ADDR_W, 16, width of all address and count fields
MAX_LAYERS, 4, maximum layers per run; LW = clog2(MAX_LAYERS)
MEM_LAT, 1, BRAM read latency in cycles, 1..3

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge in IDLE launches a run
abort  in  1  synchronous; cancels a run
cfg_layer_count  in  LW+1  number of layers for this run
cfg_idx  out  LW  layer index being looked up
cfg_num_in  in  ADDR_W  inputs of layer cfg_idx, combinational from regfile
cfg_num_out  in  ADDR_W  outputs of layer cfg_idx
cfg_act  in  2  activation type of layer cfg_idx
act_rd_addr  out  ADDR_W  batch base address, activation read
act_rd_bank  out  1  activation bank read
wt_rd_addr  out  ADDR_W  batch base address, weight read
bias_rd_addr  out  ADDR_W  bias address, global neuron counter
mac_enable  out  1  batch data valid at datapath
mac_clear  out  1  clear accumulator
mac_last  out  1  qualifies final mac_enable of a neuron
lane_mask  out  LANES  valid lanes, aligned with mac_enable
mac_valid  in  1  accumulation of final batch complete
act_enable  out  1  one-cycle: add bias and apply activation
act_type  out  2  activation type, held for the whole layer
result_valid  in  1  activated result ready
out_wr_en  out  1  output write strobe
out_wr_addr  out  ADDR_W  neuron index within the layer
out_wr_bank  out  1  equals ~act_rd_bank
layer_idx  out  LW  current layer
busy  out  1  run in progress
done  out  1  run finished; held
error  out  1  config error; held with done

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States and transitions:
  - IDLE: on a start rising edge go to CFG with layer_idx=0, bias counter=0, weight pointer=0, read bank=0.
  - CFG: cfg_idx=layer_idx. Latch num_in, num_out and act. Compute nb=ceil(num_in/LANES) and rem=num_in mod LANES. If num_in==0, num_out==0, cfg_layer_count==0 or cfg_layer_count>MAX_LAYERS, go to DONE with error=1 and perform no writes. Otherwise go to INIT with neuron=0.
  - INIT: pulse mac_clear for 1 cycle; batch=0; act_rd_addr=0; wt_rd_addr=weight pointer.
  - ISSUE: present one batch address per cycle with no bubbles. act_rd_addr and wt_rd_addr each advance by LANES. After nb cycles go to DRAIN.
  - DRAIN: wait for mac_valid, then go to ACT.
  - ACT: pulse act_enable for 1 cycle, then wait for result_valid. When it arrives go to STORE.
  - STORE: out_wr_en=1 for exactly 1 cycle. Then: neuron+1; bias+1; weight pointer += num_in. If neuron<num_out go to INIT. Else if layer_idx+1<cfg_layer_count go to CFG, incrementing layer_idx and toggling act_rd_bank. Else go to DONE.
  - DONE: busy=0; done=1 (error as set). Go to IDLE when start==0.
- Pipeline alignment:
  - mac_enable, mac_last and lane_mask are the issue-cycle strobes delayed by exactly MEM_LAT cycles through a shift register.
  - mac_last marks batch nb-1.
  - lane_mask is all ones, except on the last batch when rem!=0, where it is (1<<rem)-1.
  - mac_valid is ignored until the delayed mac_last has been emitted.
  - The shift register flushes before DRAIN exits.
- Addressing and flags:
  - Weights are packed contiguously across layers.
  - bias_rd_addr never resets between layers.
  - act_type is driven from the latched act for the whole layer.
- busy is 1 from CFG through STORE.
- start is ignored while busy.
- start held high after DONE does not relaunch a run.
- done and error clear on entering IDLE.
- abort in any non-IDLE state:
  - next cycle state=IDLE.
  - All strobes and the delay pipeline clear immediately.
  - done=0 and error=0.
  - No further out_wr_en.
- Address arithmetic wraps modulo 2^ADDR_W without saturation.
- Asynchronous reset mid-run returns everything to reset values.

Test Plan:
1. LANES=8, MEM_LAT=1, 1 layer, num_in=16, num_out=2, act=0. Required: per neuron, mac_clear, then 2 back-to-back mac_enable with mask FF and mac_last on the 2nd. out_wr_addr 0,1 on bank 1; wt_rd_addr bases 0,16; bias 0,1; done held until start drops.
2. num_in=13, LANES=8. Required: 2 batches; lane_mask FF then 1F; mac_last on the 2nd.
3. 3 layers: (4→3), (3→2), (2→1) with act 0, 1, 2. Required:
   - read banks 0/1/0 and write banks 1/0/1.
   - weight pointers 0,4,8 | 12,15 | 18.
   - bias 0..5 continuous; act_type changes only at CFG.
   - 6 writes total.
4. MEM_LAT=3. Required: mac_enable lags the first address by 3 cycles; mac_valid pulsed early is ignored; transition only on the post-last mac_valid.
5. cfg_num_out=0, and separately cfg_layer_count=5 with MAX_LAYERS=4. Required: done=1 and error=1 within 3 cycles of start; zero out_wr_en.
6. abort asserted mid-ISSUE in layer 1. Required: next cycle busy=0 and all strobes 0; a new start runs cleanly from layer 0 and bias 0.
